// File: rtl/uart_mmio_pkg.sv
// Shared constants and helpers for the memory-mapped UART byte-FIFO bridge.
package uart_mmio_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned BYTE_W = 8;

    localparam logic [DATA_W-1:0] OFF_STATUS  = 32'h0;
    localparam logic [DATA_W-1:0] OFF_RX_DATA = 32'h4;
    localparam logic [DATA_W-1:0] OFF_TX_DATA = 32'h8;
    localparam logic [DATA_W-1:0] OFF_LEVELS  = 32'hC;

    localparam int unsigned ST_TX_NOT_FULL  = 0;
    localparam int unsigned ST_RX_NOT_EMPTY = 1;
    localparam int unsigned ST_TX_OVERFLOW  = 2;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_STATUS,
        SEL_RX_DATA,
        SEL_TX_DATA,
        SEL_LEVELS
    } reg_sel_e;

    function automatic reg_sel_e decode_offset(input logic [DATA_W-1:0] off);
        case (off)
            OFF_STATUS:  return SEL_STATUS;
            OFF_RX_DATA: return SEL_RX_DATA;
            OFF_TX_DATA: return SEL_TX_DATA;
            OFF_LEVELS:  return SEL_LEVELS;
            default:     return SEL_NONE;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] level_word(input logic [BYTE_W-1:0] rx_cnt,
                                                     input logic [BYTE_W-1:0] tx_cnt);
        return {16'h0, tx_cnt, rx_cnt};
    endfunction

endpackage

// File: rtl/uart_mmio_if.sv
// CPU MMIO port plus the ready/valid byte streams toward the existing UART core.
interface uart_mmio_if;
    import uart_mmio_pkg::*;

    logic [DATA_W-1:0] addr;
    logic              re;
    logic [STRB_W-1:0] we;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (
        output addr, re, we, wdata, tx_ready, rx_data, rx_valid,
        input  rdata, tx_data, tx_valid, rx_ready
    );

    modport slave (
        input  addr, re, we, wdata, tx_ready, rx_data, rx_valid,
        output rdata, tx_data, tx_valid, rx_ready
    );

endinterface

// File: rtl/uart_mmio_fifo.sv
// Power-of-two synchronous FIFO with occupancy count; head is read combinationally.
module uart_mmio_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_c, pop_ok_c;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // A pop frees the slot a same-cycle push needs, so full+pop still accepts.
    assign pop_ok_c  = pop_i && !empty_o;
    assign push_ok_c = push_i && (!full_o || pop_ok_c);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
        if (push_ok_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_c) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/uart_mmio.sv
// MMIO register front-end bridging CPU loads/stores to RX/TX byte FIFOs of a UART core.
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 125_000_000,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
    input logic        clk,
    input logic        reset,
    uart_mmio_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    if (CLOCK_FREQ == 0 || FIFO_DEPTH < 2 || FIFO_DEPTH > 64 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("uart_mmio: CLOCK_FREQ must be nonzero, FIFO_DEPTH a power of two in 2..64");
    end

    logic [DATA_W-1:0] off_c;
    reg_sel_e          sel_c;
    logic              tx_wr_c, tx_pop_c, tx_ovf_c, clr_c;
    logic              rx_push_c, rx_pop_c, rx_ready_c;
    logic              rx_full, rx_empty, tx_full, tx_empty;
    logic [BYTE_W-1:0] rx_head, tx_head;
    logic [CNT_W-1:0]  rx_cnt, tx_cnt;
    logic [DATA_W-1:0] status_c;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              sticky_q, sticky_d;
    logic              unused_wdata_hi;

    assign unused_wdata_hi = ^bus.wdata[DATA_W-1:BYTE_W];

    assign off_c = bus.addr - BASE_ADDR;
    assign sel_c = decode_offset(off_c);

    assign tx_wr_c  = (sel_c == SEL_TX_DATA) && bus.we[0];
    assign clr_c    = (sel_c == SEL_STATUS) && (|bus.we);
    assign tx_pop_c = !tx_empty && bus.tx_ready;
    assign tx_ovf_c = tx_wr_c && tx_full && !tx_pop_c;

    assign rx_pop_c   = bus.re && (sel_c == SEL_RX_DATA) && !rx_empty;
    // A CPU pop in the same cycle makes room, so a full RX FIFO can still take a byte.
    assign rx_ready_c = !rx_full || rx_pop_c;
    assign rx_push_c  = bus.rx_valid && rx_ready_c;

    uart_mmio_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (rx_push_c),
        .data_i  (bus.rx_data),
        .pop_i   (rx_pop_c),
        .data_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_cnt)
    );

    uart_mmio_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (tx_wr_c),
        .data_i  (bus.wdata[BYTE_W-1:0]),
        .pop_i   (tx_pop_c),
        .data_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_cnt)
    );

    always_comb begin
        status_c                  = '0;
        status_c[ST_TX_NOT_FULL]  = !tx_full;
        status_c[ST_RX_NOT_EMPTY] = !rx_empty;
        status_c[ST_TX_OVERFLOW]  = sticky_q;
    end

    // Read data reflects pre-edge state; rdata holds between reads.
    always_comb begin
        rdata_d = rdata_q;
        if (bus.re) begin
            case (sel_c)
                SEL_STATUS:  rdata_d = status_c;
                SEL_RX_DATA: rdata_d = rx_empty ? '0 : DATA_W'(rx_head);
                SEL_LEVELS:  rdata_d = level_word(BYTE_W'(rx_cnt), BYTE_W'(tx_cnt));
                default:     rdata_d = '0;
            endcase
        end
    end

    // Overflow wins over a same-cycle clear.
    always_comb begin
        sticky_d = sticky_q;
        if (clr_c)    sticky_d = 1'b0;
        if (tx_ovf_c) sticky_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.tx_data  = tx_head;
    assign bus.tx_valid = !tx_empty;
    assign bus.rx_ready = rx_ready_c;

endmodule
